// File: rtl/axi_lite_pwm.sv
// axi_lite_pwm: four-channel PWM generator behind an AXI4-Lite slave.
//
// Ports
//   clk, resetn          single clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*      AXI4-Lite write address / data / response channels
//   s_axi_ar*/r*         AXI4-Lite read address / data channels
//   pwm_out[3:0]         registered PWM outputs, one per channel
//
// Registers (word offsets): 0x00 CTRL.EN, 0x04 PERIOD, 0x08..0x14 DUTY0..3,
// 0x18 COUNT (read-only live counter). PERIOD/DUTY are shadowed and only
// take effect at a period wrap or while the block is disabled.
module axi_lite_pwm #(
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [3:0]            pwm_out
);

  localparam int IW = ADDR_WIDTH - 2;

  logic                      aw_held_q, aw_held_d;
  logic [IW-1:0]             awidx_q, awidx_d;
  logic                      w_held_q, w_held_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      en_q, en_d;
  logic [CNT_WIDTH-1:0]      period_q, period_d;
  logic [3:0][CNT_WIDTH-1:0] duty_q, duty_d;
  logic [CNT_WIDTH-1:0]      act_period_q, act_period_d;
  logic [3:0][CNT_WIDTH-1:0] act_duty_q, act_duty_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [3:0]                pwm_q, pwm_d;

  logic        aw_hs, w_hs, ar_hs, do_wr, wrap;
  logic [31:0] wmask, wi, ri, per_m, duty_m;
  logic [1:0]  wsel, rsel;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign pwm_out       = pwm_q;

  always_comb begin
    aw_held_d    = aw_held_q;
    awidx_d      = awidx_q;
    w_held_d     = w_held_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    en_d         = en_q;
    period_d     = period_q;
    duty_d       = duty_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;

    aw_hs = s_axi_awvalid && awready_q;
    w_hs  = s_axi_wvalid && wready_q;
    ar_hs = s_axi_arvalid && arready_q;
    do_wr = aw_held_q && w_held_q;

    wmask  = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    wi     = 32'(awidx_q);
    ri     = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);
    // DUTY0..3 live at word 2..5; low two index bits minus 2 pick the channel
    wsel   = wi[1:0] - 2'd2;
    rsel   = ri[1:0] - 2'd2;
    per_m  = (32'(period_q) & ~wmask) | (wdata_q & wmask);
    duty_m = (32'(duty_q[wsel]) & ~wmask) | (wdata_q & wmask);

    // Write path: each beat is parked independently, commit once both are held
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = s_axi_awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end
    if (do_wr) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = 2'b00;
      case (wi)
        0:          en_d = wstrb_q[0] ? wdata_q[0] : en_q;
        1:          period_d = per_m[CNT_WIDTH-1:0];
        2, 3, 4, 5: duty_d[wsel] = duty_m[CNT_WIDTH-1:0];
        default:    bresp_d = 2'b10;
      endcase
    end
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;

    // Read path samples current register values, so a same-cycle write is
    // not visible until the next read.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = 2'b00;
      case (ri)
        0:          rdata_d = {31'b0, en_q};
        1:          rdata_d = 32'(period_q);
        2, 3, 4, 5: rdata_d = 32'(duty_q[rsel]);
        6:          rdata_d = 32'(cnt_q);
        default: begin
          rdata_d = 32'b0;
          rresp_d = 2'b10;
        end
      endcase
    end
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    arready_d = !rvalid_d;

    // PWM core. Shadows reload from the programmed values (pre-write this
    // cycle) at every wrap and continuously while disabled.
    wrap  = (cnt_q == act_period_q);
    cnt_d = (en_q && !wrap) ? cnt_q + CNT_WIDTH'(1) : '0;
    if (!en_q || wrap) begin
      act_period_d = period_q;
      act_duty_d   = duty_q;
    end
    for (int i = 0; i < 4; i++) pwm_d[i] = en_q && (cnt_q < act_duty_q[i]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held_q    <= 1'b0;
      awidx_q      <= '0;
      w_held_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= '0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      en_q         <= 1'b0;
      period_q     <= '0;
      duty_q       <= '0;
      act_period_q <= '0;
      act_duty_q   <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
    end else begin
      aw_held_q    <= aw_held_d;
      awidx_q      <= awidx_d;
      w_held_q     <= w_held_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      en_q         <= en_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_pwm.sv
// Randomized + directed bench for axi_lite_pwm with an in-bench register /
// PWM model and a per-cycle pwm_out comparison.
module tb_axi_lite_pwm;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [4:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [3:0]  pwm_out;

  axi_lite_pwm #(.CNT_WIDTH(16), .ADDR_WIDTH(5)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // m_reg[word] holds programmed values; m_cnt is the position within the
  // current period; m_aper/m_aduty are the settings that period runs with.
  logic [31:0] m_reg [0:5];
  logic [31:0] m_cnt, m_aper;
  logic [31:0] m_aduty [0:3];
  logic [3:0]  m_pwm;
  logic        m_wr = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s, input logic [2:0] idx);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return (idx == 3'd0) ? (r & 32'h1) : (r & 32'hFFFF);
  endfunction

  function automatic logic [33:0] m_read(input logic [4:0] a);
    if (a[4:2] <= 3'd5) return {2'b00, m_reg[a[4:2]]};
    if (a[4:2] == 3'd6) return {2'b00, m_cnt};
    return {2'b10, 32'h0};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 6; i++) m_reg[i] <= '0;
      for (int i = 0; i < 4; i++) m_aduty[i] <= '0;
      m_cnt  <= '0;
      m_aper <= '0;
      m_pwm  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) m_pwm[i] <= m_reg[0][0] && (m_cnt < m_aduty[i]);
      if (m_reg[0][0] && m_cnt != m_aper) m_cnt <= m_cnt + 1;
      else begin
        // a new period starts (or we sit idle): adopt programmed settings
        m_cnt  <= '0;
        m_aper <= m_reg[1];
        for (int i = 0; i < 4; i++) m_aduty[i] <= m_reg[2+i];
      end
      if (m_wr && m_waddr[4:2] <= 3'd5)
        m_reg[m_waddr[4:2]] <= m_merge(m_reg[m_waddr[4:2]], m_wdata, m_wstrb, m_waddr[4:2]);
    end
  end

  always @(negedge clk) if (resetn) chk("pwm_out", 32'(pwm_out), 32'(m_pwm));

  // ---------------- bus tasks (called at a negedge) ----------------
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_ok = 0;
    bit w_ok = 0;
    logic [1:0] exp_resp;
    exp_resp = (a[4:2] <= 3'd5) ? 2'b00 : 2'b10;
    fork
      begin
        repeat (aw_dly) @(negedge clk);
        s_axi_awaddr = a; s_axi_awprot = 3'($urandom); s_axi_awvalid = 1'b1;
        for (int k = 0; k < 40 && !aw_ok; k++) begin
          if (s_axi_awready) aw_ok = 1;
          @(negedge clk);
        end
        s_axi_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge clk);
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        for (int k = 0; k < 40 && !w_ok; k++) begin
          if (s_axi_wready) w_ok = 1;
          @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
      end
    join
    if (!aw_ok || !w_ok) begin
      checks++; errors++;
      $display("FAIL wr_handshake addr %0h aw %0d w %0d", a, aw_ok, w_ok);
      return;
    end
    m_wr = 1'b1; m_waddr = a; m_wdata = d; m_wstrb = s;
    @(negedge clk);
    m_wr = 1'b0;
    chk("bvalid", 32'(s_axi_bvalid), 1);
    chk("bresp", 32'(s_axi_bresp), 32'(exp_resp));
    repeat (b_dly) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(s_axi_bvalid), 1);
      chk("bresp_hold", 32'(s_axi_bresp), 32'(exp_resp));
      chk("ready_while_b", {30'b0, s_axi_awready, s_axi_wready}, 0);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("bvalid_clr", 32'(s_axi_bvalid), 0);
  endtask

  task automatic axi_read(input logic [4:0] a, input int r_dly,
                          output logic [31:0] rd, output logic [1:0] rr);
    logic [33:0] exp;
    bit ok = 0;
    exp = '0;
    s_axi_araddr = a; s_axi_arprot = 3'($urandom); s_axi_arvalid = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (s_axi_arready) begin
        ok = 1;
        exp = m_read(a);
      end
      @(negedge clk);
    end
    s_axi_arvalid = 1'b0;
    rd = '0; rr = '0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rd_handshake addr %0h", a);
      return;
    end
    chk("rvalid", 32'(s_axi_rvalid), 1);
    chk("rdata", s_axi_rdata, exp[31:0]);
    chk("rresp", 32'(s_axi_rresp), 32'(exp[33:32]));
    rd = s_axi_rdata; rr = s_axi_rresp;
    repeat (r_dly) begin
      @(negedge clk);
      chk("rvalid_hold", 32'(s_axi_rvalid), 1);
      chk("rdata_hold", s_axi_rdata, exp[31:0]);
      chk("arready_while_r", 32'(s_axi_arready), 0);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("rvalid_clr", 32'(s_axi_rvalid), 0);
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    bit ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (m_cnt == v) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_cnt got %0h want %0h", m_cnt, v);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(pwm_out[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    chk("rst_valid", {30'b0, s_axi_bvalid, s_axi_rvalid}, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_resp", {28'b0, s_axi_bresp, s_axi_rresp}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // 10-cycle period, 3 high
    axi_write(5'h04, 9, 4'hF, 0, 0, 0);
    axi_write(5'h08, 3, 4'hF, 0, 0, 0);
    axi_write(5'h00, 1, 4'hF, 0, 0, 0);
    wait_cnt(0);
    count_high(n);
    chk("duty3_of_10", n, 6);
    repeat (4) begin
      axi_read(5'h18, 0, rd, rr);
      chk("count_range", 32'(rd <= 9), 1);
    end

    // data beat two cycles ahead of address beat
    axi_write(5'h0C, 5, 4'hF, 2, 0, 0);
    axi_read(5'h0C, 0, rd, rr);
    chk("duty1_w_first", rd, 5);

    // mid-period duty change only lands after the wrap
    wait_cnt(2);
    axi_write(5'h08, 7, 4'hF, 0, 0, 0);
    wait_cnt(0);
    count_high(n);
    chk("duty7_of_10", n, 14);

    // read-only / unmapped
    axi_write(5'h18, 5, 4'hF, 0, 0, 0);
    axi_read(5'h1C, 0, rd, rr);
    chk("unmapped_rresp", 32'(rr), 2);
    chk("unmapped_rdata", rd, 0);

    // stalled responses
    axi_write(5'h10, 32'h1234, 4'hF, 0, 0, 5);
    axi_read(5'h10, 5, rd, rr);
    chk("duty2_stall", rd, 32'h1234);

    // byte strobes, while disabled
    axi_write(5'h00, 0, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'hABCD_5678, 4'b0010, 0, 0, 0);
    axi_read(5'h04, 0, rd, rr);
    chk("period_strobe", rd, 32'h5609);
    axi_read(5'h00, 0, rd, rr);
    chk("ctrl_off", rd, 0);

    // read landing on the same edge as a write sees the old value
    fork
      axi_write(5'h14, 2, 4'hF, 0, 0, 0);
      begin
        logic [31:0] rd2;
        logic [1:0]  rr2;
        @(negedge clk);
        axi_read(5'h14, 0, rd2, rr2);
        chk("rd_during_wr", rd2, 0);
      end
    join
    axi_read(5'h14, 0, rd, rr);
    chk("rd_after_wr", rd, 2);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      logic [4:0]  a;
      logic [31:0] d;
      int          op;
      a  = 5'($urandom_range(0, 31));
      d  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 24);
      op = $urandom_range(0, 2);
      if (op == 0)
        axi_write(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      else if (op == 1)
        axi_read(a, $urandom_range(0, 3), rd, rr);
      else
        fork
          axi_write(a, d, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
          begin
            logic [31:0] rd3;
            logic [1:0]  rr3;
            axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 2), rd3, rr3);
          end
        join
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // reset in the middle of a running period
    axi_write(5'h00, 0, 4'hF, 0, 0, 0);
    axi_write(5'h04, 9, 4'hF, 0, 0, 0);
    axi_write(5'h08, 5, 4'hF, 0, 0, 0);
    axi_write(5'h00, 1, 4'hF, 0, 0, 0);
    wait_cnt(4);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_pwm", 32'(pwm_out), 0);
    chk("midrst_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    chk("midrst_valid", {30'b0, s_axi_bvalid, s_axi_rvalid}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    for (int w = 0; w < 7; w++) begin
      axi_read(5'(w * 4), 0, rd, rr);
      chk("reg_after_rst", rd, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
